// File: rtl/i_cache_assoc_pkg.sv
// ============================================================================
// Module  : i_cache_assoc_pkg
// Brief   : Shared constants and state encoding for the 2-way instruction cache
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i_cache_assoc_pkg;

  localparam int WORD_SIZE = 16;
  localparam int LINE_SIZE = 4;
  localparam int SET_COUNT = 2;

  // Field widths for the default geometry; instances recompute from their own parameters
  localparam int OB = $clog2(LINE_SIZE);
  localparam int IB = $clog2(SET_COUNT);
  localparam int TB = WORD_SIZE - OB - IB;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i_cache_way_store.sv
// ============================================================================
// Module  : i_cache_way_store
// Brief   : Tag/valid/data arrays for two ways plus per-set LRU victim bits
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i_cache_way_store
  import i_cache_assoc_pkg::*;
#(
  parameter int WORD_W     = WORD_SIZE,
  parameter int LINE_WORDS = LINE_SIZE,
  parameter int SETS       = SET_COUNT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_flush,
  input  logic [$clog2(SETS)-1:0]      i_rd_index,
  output logic [1:0]                   o_valid,
  output logic [WORD_W-$clog2(LINE_WORDS)-$clog2(SETS)-1:0] o_tag0,
  output logic [WORD_W-$clog2(LINE_WORDS)-$clog2(SETS)-1:0] o_tag1,
  output logic [WORD_W*LINE_WORDS-1:0] o_line0,
  output logic [WORD_W*LINE_WORDS-1:0] o_line1,
  output logic                         o_lru,
  input  logic                         i_wr_en,
  input  logic                         i_wr_way,
  input  logic [$clog2(SETS)-1:0]      i_wr_index,
  input  logic [WORD_W-$clog2(LINE_WORDS)-$clog2(SETS)-1:0] i_wr_tag,
  input  logic [WORD_W*LINE_WORDS-1:0] i_wr_line,
  input  logic                         i_lru_en,
  input  logic [$clog2(SETS)-1:0]      i_lru_index,
  input  logic                         i_lru_val
);

  localparam int TAG_W  = WORD_W - $clog2(LINE_WORDS) - $clog2(SETS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  logic [SETS-1:0]   r_valid0;
  logic [SETS-1:0]   r_valid1;
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag0  [SETS];
  logic [TAG_W-1:0]  r_tag1  [SETS];
  logic [LINE_W-1:0] r_data0 [SETS];
  logic [LINE_W-1:0] r_data1 [SETS];

  assign o_valid = {r_valid1[i_rd_index], r_valid0[i_rd_index]};
  assign o_tag0  = r_tag0[i_rd_index];
  assign o_tag1  = r_tag1[i_rd_index];
  assign o_line0 = r_data0[i_rd_index];
  assign o_line1 = r_data1[i_rd_index];
  assign o_lru   = r_lru[i_rd_index];

  // Flush shares the reset path: only valid and LRU state needs clearing
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (i_wr_en) begin
        if (i_wr_way) r_valid1[i_wr_index] <= 1'b1;
        else          r_valid0[i_wr_index] <= 1'b1;
      end
      if (i_lru_en) r_lru[i_lru_index] <= i_lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_way) begin
        r_tag1[i_wr_index]  <= i_wr_tag;
        r_data1[i_wr_index] <= i_wr_line;
      end else begin
        r_tag0[i_wr_index]  <= i_wr_tag;
        r_data0[i_wr_index] <= i_wr_line;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i_cache_assoc.sv
// ============================================================================
// Module  : i_cache_assoc
// Brief   : 2-way set-associative read-only instruction cache with LRU and perf counters
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i_cache_assoc
  import i_cache_assoc_pkg::*;
#(
  parameter int WORD_W      = WORD_SIZE,
  parameter int LINE_WORDS  = LINE_SIZE,
  parameter int SETS        = SET_COUNT,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WORD_W-1:0]            pc,
  input  logic                         fetch,
  input  logic                         flush,
  output logic [WORD_W-1:0]            inst,
  output logic                         inst_valid,
  output logic                         readM1,
  output logic [WORD_W-1:0]            address1,
  input  logic [WORD_W*LINE_WORDS-1:0] data1,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_W - OFF_W - IDX_W;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int CNT_LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_LW-1:0] CNT_LAST = CNT_LW'(MEM_LATENCY - 1);

  logic [0:0]        r_state;
  logic [CNT_LW-1:0] r_cnt;
  logic [WORD_W-1:0] r_line_addr;
  logic [IDX_W-1:0]  r_index;
  logic              r_victim;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic [OFF_W-1:0]  w_offset;
  logic [IDX_W-1:0]  w_index;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_valid;
  logic [TAG_W-1:0]  w_tag0;
  logic [TAG_W-1:0]  w_tag1;
  logic [LINE_W-1:0] w_line0;
  logic [LINE_W-1:0] w_line1;
  logic [LINE_W-1:0] w_hit_line;
  logic [WORD_W-1:0] w_word;
  logic              w_lru;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_hit_way;
  logic              w_hit_fire;
  logic              w_miss_fire;
  logic              w_fill_done;
  logic              w_victim;

  assign w_offset = pc[OFF_W-1:0];
  assign w_index  = pc[OFF_W +: IDX_W];
  assign w_tag    = pc[WORD_W-1 -: TAG_W];

  assign w_hit0    = w_valid[0] && (w_tag0 == w_tag);
  assign w_hit1    = w_valid[1] && (w_tag1 == w_tag);
  assign w_hit_way = !w_hit0;
  assign w_hit_line = w_hit0 ? w_line0 : w_line1;

  assign w_hit_fire  = (r_state == IDLE) && fetch && (w_hit0 || w_hit1) && !flush;
  assign w_miss_fire = (r_state == IDLE) && fetch && !(w_hit0 || w_hit1) && !flush;
  assign w_fill_done = (r_state == FILL) && (r_cnt == CNT_LAST) && !flush;
  assign w_victim    = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : w_lru);

  // Word 0 sits in the most significant slice of the line
  always_comb begin
    w_word = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (w_offset == OFF_W'(k)) w_word = w_hit_line[(LINE_WORDS-1-k)*WORD_W +: WORD_W];
    end
  end

  assign inst_valid = w_hit_fire;
  assign inst       = w_hit_fire ? w_word : '0;
  assign readM1     = (r_state == FILL);
  assign address1   = (r_state == FILL) ? r_line_addr : '0;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  i_cache_way_store #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS)
  ) u_store (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (flush),
    .i_rd_index  (w_index),
    .o_valid     (w_valid),
    .o_tag0      (w_tag0),
    .o_tag1      (w_tag1),
    .o_line0     (w_line0),
    .o_line1     (w_line1),
    .o_lru       (w_lru),
    .i_wr_en     (w_fill_done),
    .i_wr_way    (r_victim),
    .i_wr_index  (r_index),
    .i_wr_tag    (r_line_addr[WORD_W-1 -: TAG_W]),
    .i_wr_line   (data1),
    .i_lru_en    (w_fill_done || w_hit_fire),
    .i_lru_index (w_fill_done ? r_index : w_index),
    .i_lru_val   (w_fill_done ? !r_victim : !w_hit_way)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_line_addr  <= '0;
      r_index      <= '0;
      r_victim     <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit_fire) begin
            if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_W'(1);
          end else if (w_miss_fire) begin
            r_line_addr <= {pc[WORD_W-1:OFF_W], OFF_W'(0)};
            r_index     <= w_index;
            r_victim    <= w_victim;
            r_cnt       <= '0;
            r_state     <= FILL;
            if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt + CNT_LW'(1);
          if (r_cnt == CNT_LAST) r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i_cache_assoc.sv
// ============================================================================
// Module  : tb_i_cache_assoc
// Brief   : Directed self-checking bench for the default and a small swept cache geometry
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i_cache_assoc;

  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D2 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] P0 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;

  logic        clk = 1'b0;
  logic        reset_n, fetch, flush;
  logic [15:0] pc;
  logic [63:0] data1;
  logic [15:0] inst, address1, hit_count, miss_count;
  logic        inst_valid, readM1;

  logic         p_reset_n, p_fetch, p_flush;
  logic [15:0]  p_pc;
  logic [127:0] p_data1;
  logic [15:0]  p_inst, p_address1;
  logic         p_inst_valid, p_readM1;
  logic [1:0]   p_hit_count, p_miss_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  i_cache_assoc dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .fetch(fetch), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .readM1(readM1), .address1(address1),
    .data1(data1), .hit_count(hit_count), .miss_count(miss_count)
  );

  i_cache_assoc #(
    .WORD_W(16), .LINE_WORDS(8), .SETS(4), .MEM_LATENCY(1), .CNT_W(2)
  ) dut_p (
    .clk(clk), .reset_n(p_reset_n), .pc(p_pc), .fetch(p_fetch), .flush(p_flush),
    .inst(p_inst), .inst_valid(p_inst_valid), .readM1(p_readM1), .address1(p_address1),
    .data1(p_data1), .hit_count(p_hit_count), .miss_count(p_miss_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss on pc, then ride out the fill; returns in the first cycle the line can hit
  task automatic fill_line(input logic [15:0] a, input logic [63:0] line, input string tag);
    pc = a; data1 = line; fetch = 1'b1;
    #1;
    chk(tag, {63'd0, inst_valid}, 64'd0);
    repeat (5) tick();
  endtask

  initial begin
    reset_n = 1'b0; fetch = 1'b0; flush = 1'b0; pc = '0; data1 = '0;
    p_reset_n = 1'b0; p_fetch = 1'b0; p_flush = 1'b0; p_pc = '0; p_data1 = '0;
    repeat (2) tick();
    reset_n = 1'b1; p_reset_n = 1'b1;
    #1;
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {48'd0, inst}, 64'd0);
    chk("rst_readM1", {63'd0, readM1}, 64'd0);
    chk("rst_address1", {48'd0, address1}, 64'd0);
    chk("rst_hits", {48'd0, hit_count}, 64'd0);
    chk("rst_misses", {48'd0, miss_count}, 64'd0);

    // Cold miss
    pc = 16'h0010; data1 = D0; fetch = 1'b1;
    #1;
    chk("cold_miss_valid", {63'd0, inst_valid}, 64'd0);
    chk("cold_miss_readM1", {63'd0, readM1}, 64'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("fill_readM1", {63'd0, readM1}, 64'd1);
      chk("fill_address1", {48'd0, address1}, 64'h0010);
      chk("fill_inst_valid", {63'd0, inst_valid}, 64'd0);
      tick();
    end
    chk("cold_hit_inst", {48'd0, inst}, 64'h1111);
    chk("cold_hit_valid", {63'd0, inst_valid}, 64'd1);
    chk("cold_miss_count", {48'd0, miss_count}, 64'd1);
    tick();
    pc = 16'h0012;
    #1;
    chk("offset2_inst", {48'd0, inst}, 64'h3333);
    tick();
    chk("hit_count_2", {48'd0, hit_count}, 64'd2);

    // Second line in the same set lands in the other way
    fill_line(16'h0020, D1, "miss_0020");
    chk("way1_inst", {48'd0, inst}, 64'h5555);
    tick();
    pc = 16'h0010; #1;
    chk("alt_0010", {48'd0, inst}, 64'h1111);
    tick();
    pc = 16'h0023; #1;
    chk("alt_0023", {48'd0, inst}, 64'h8888);
    tick();
    chk("twoway_misses", {48'd0, miss_count}, 64'd2);
    chk("twoway_hits", {48'd0, hit_count}, 64'd5);

    // LRU eviction: touching 0x0010 makes 0x0020 the victim
    pc = 16'h0010; #1;
    chk("lru_touch", {63'd0, inst_valid}, 64'd1);
    tick();
    fill_line(16'h0030, D2, "miss_0030");
    chk("evict_inst", {48'd0, inst}, 64'h9999);
    tick();
    pc = 16'h0010; #1;
    chk("survivor_hit", {48'd0, inst}, 64'h1111);
    tick();
    pc = 16'h0020; data1 = D1; #1;
    chk("evicted_miss", {63'd0, inst_valid}, 64'd0);
    tick();
    chk("evict_miss_count", {48'd0, miss_count}, 64'd4);
    repeat (4) tick();
    chk("refill_0020", {48'd0, inst}, 64'h5555);
    tick();

    // Flush of a resident line
    pc = 16'h0010; data1 = D0; flush = 1'b1; #1;
    chk("flush_cycle_valid", {63'd0, inst_valid}, 64'd0);
    tick();
    flush = 1'b0; #1;
    chk("post_flush_miss", {63'd0, inst_valid}, 64'd0);
    tick();
    chk("post_flush_misses", {48'd0, miss_count}, 64'd5);

    // Flush during FILL cycle 2 abandons the fill
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("flush_fill_readM1", {63'd0, readM1}, 64'd0);
    chk("flush_fill_not_installed", {63'd0, inst_valid}, 64'd0);
    tick();
    chk("flush_fill_misses", {48'd0, miss_count}, 64'd6);
    repeat (4) tick();
    chk("flush_refill_inst", {48'd0, inst}, 64'h1111);
    tick();

    // Reset during FILL cycle 2
    pc = 16'h0020; data1 = D1; #1;
    chk("pre_rst_miss", {63'd0, inst_valid}, 64'd0);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; fetch = 1'b0; #1;
    chk("midrst_readM1", {63'd0, readM1}, 64'd0);
    chk("midrst_address1", {48'd0, address1}, 64'd0);
    chk("midrst_hits", {48'd0, hit_count}, 64'd0);
    chk("midrst_misses", {48'd0, miss_count}, 64'd0);
    fetch = 1'b1; #1;
    chk("midrst_not_installed", {63'd0, inst_valid}, 64'd0);
    fetch = 1'b0;

    // Swept geometry: 4 sets, 8-word lines, single-cycle memory, 2-bit counters
    p_pc = 16'h0048; p_data1 = P0; p_fetch = 1'b1; #1;
    chk("p_miss", {63'd0, p_inst_valid}, 64'd0);
    tick();
    chk("p_fill_readM1", {63'd0, p_readM1}, 64'd1);
    chk("p_fill_address1", {48'd0, p_address1}, 64'h0048);
    tick();
    chk("p_hit_inst", {48'd0, p_inst}, 64'h0001);
    chk("p_hit_valid", {63'd0, p_inst_valid}, 64'd1);
    tick();
    p_pc = 16'h004F; #1;
    chk("p_last_word", {48'd0, p_inst}, 64'h0008);
    repeat (3) tick();
    chk("p_hit_saturate", {62'd0, p_hit_count}, 64'd3);
    chk("p_miss_count", {62'd0, p_miss_count}, 64'd1);
    p_fetch = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
